// File: rtl/day10_pkg.sv
// Shared types and constants for the day10 answer accumulator.
// The saturating-sum option is selected by defining DAY10_ACC_SATURATE_EN.
package day10_pkg;

  // Accumulator control states.
  typedef enum logic [1:0] {
    ACCUMULATE = 2'd0,
    EMIT       = 2'd1,
    CLEAR      = 2'd2
  } acc_state_t;

  // Default accumulator width.
  localparam int unsigned SUM_WIDTH_DEFAULT = 32;

  // Width of a counter able to index 'beats' entries (never narrower than 1 bit).
  function automatic int unsigned idx_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle used by the day10 answer accumulator.
interface axi_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/day10_sum_serializer.sv
// Serializes the accumulated sum onto the output stream, least-significant
// beat first. Owns the beat index, the slice mux and the tlast flag.
module day10_sum_serializer
  import day10_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = SUM_WIDTH_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              emit_i,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic              tready_i,
  output logic              tvalid_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tlast_o,
  output logic              last_fire_o
);

  localparam int unsigned NBEATS = SUM_W / DATA_W;
  localparam int unsigned IDX_W  = idx_width(NBEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  logic [IDX_W-1:0]  beat_idx_q;
  logic [IDX_W-1:0]  beat_idx_d;
  logic [DATA_W-1:0] slice;
  logic              is_last;
  logic              fire;

  assign is_last     = (beat_idx_q == LAST_IDX);
  assign fire        = emit_i && tready_i;
  assign last_fire_o = fire && is_last;

  // Beat index: step on each non-final output transfer, zero on clear.
  always_comb begin
    beat_idx_d = beat_idx_q;
    if (clear_i) begin
      beat_idx_d = '0;
    end else if (fire && !is_last) begin
      beat_idx_d = beat_idx_q + 1'b1;
    end
  end

  // Beat index register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_idx_q <= '0;
    end else begin
      beat_idx_q <= beat_idx_d;
    end
  end

  // Slice mux selecting the current beat of the sum.
  always_comb begin
    slice = '0;
    for (int unsigned b = 0; b < NBEATS; b++) begin
      if (beat_idx_q == IDX_W'(b)) begin
        slice = sum_i[b*DATA_W +: DATA_W];
      end
    end
  end

  // Outputs stay quiet (all zero) outside EMIT.
  assign tvalid_o = emit_i;
  assign tdata_o  = emit_i ? slice : '0;
  assign tlast_o  = emit_i && is_last;

endmodule

// File: rtl/day10_answer_accumulator.sv
// Sums per-machine press counts from the input stream and emits the total
// as SUM_WIDTH/AXI_DATA_WIDTH little-endian beats, then clears for the next
// dataset. Defining DAY10_ACC_SATURATE_EN clamps an overflowing sum to
// all-ones; otherwise the sum wraps. Both variants set the sticky overflow.
module day10_answer_accumulator
  import day10_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 8,
  parameter int unsigned SUM_WIDTH      = SUM_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  axi_stream_if.slave  data_in,
  axi_stream_if.master data_out,
  output logic         overflow
);

  acc_state_t           state_q;
  acc_state_t           state_d;
  logic [SUM_WIDTH-1:0] sum_q;
  logic [SUM_WIDTH-1:0] sum_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [SUM_WIDTH:0]   add_full;
  logic                 in_fire;
  logic                 clear;
  logic                 last_fire;

  // Input is only accepted while accumulating and out of reset.
  assign data_in.tready = (state_q == ACCUMULATE) && !rst;
  assign in_fire        = data_in.tvalid && data_in.tready;

  // Extra top bit of the adder is the carry out used for overflow.
  assign add_full = {1'b0, sum_q}
                  + {{(SUM_WIDTH + 1 - AXI_DATA_WIDTH){1'b0}}, data_in.tdata};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    clear   = 1'b0;
    case (state_q)
      ACCUMULATE: begin
        if (in_fire) begin
`ifdef DAY10_ACC_SATURATE_EN
          sum_d = add_full[SUM_WIDTH] ? '1 : add_full[SUM_WIDTH-1:0];
`else
          sum_d = add_full[SUM_WIDTH-1:0];
`endif
          ovf_d = ovf_q | add_full[SUM_WIDTH];
          if (data_in.tlast) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (last_fire) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        sum_d   = '0;
        ovf_d   = 1'b0;
        clear   = 1'b1;
        state_d = ACCUMULATE;
      end
      default: begin
        state_d = ACCUMULATE;
      end
    endcase
  end

  // State, sum and overflow registers; reset discards any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUMULATE;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  day10_sum_serializer #(
    .DATA_W (AXI_DATA_WIDTH),
    .SUM_W  (SUM_WIDTH)
  ) u_serializer (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .emit_i      (state_q == EMIT),
    .sum_i       (sum_q),
    .tready_i    (data_out.tready),
    .tvalid_o    (data_out.tvalid),
    .tdata_o     (data_out.tdata),
    .tlast_o     (data_out.tlast),
    .last_fire_o (last_fire)
  );

endmodule

// File: tb/tb_day10_answer_accumulator.sv
// Directed self-checking bench for day10_answer_accumulator (32-bit and 8-bit sums).
module tb_day10_answer_accumulator;

  logic clk;
  logic rst;
  logic ovf;
  logic ovf8;
  int   compared;
  int   mismatched;

`ifdef DAY10_ACC_SATURATE_EN
  localparam logic [7:0] EXP8 = 8'hFF;
`else
  localparam logic [7:0] EXP8 = 8'h10;
`endif

  axi_stream_if #(.DATA_WIDTH(8)) in_if ();
  axi_stream_if #(.DATA_WIDTH(8)) out_if ();
  axi_stream_if #(.DATA_WIDTH(8)) in8_if ();
  axi_stream_if #(.DATA_WIDTH(8)) out8_if ();

  day10_answer_accumulator #(
    .AXI_DATA_WIDTH (8),
    .SUM_WIDTH      (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (in_if),
    .data_out (out_if),
    .overflow (ovf)
  );

  day10_answer_accumulator #(
    .AXI_DATA_WIDTH (8),
    .SUM_WIDTH      (8)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (in8_if),
    .data_out (out8_if),
    .overflow (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary, required completion");
    $fatal(1);
  end

  // Drive one input beat (called at a negedge); returns at the negedge after the transfer.
  task automatic send_beat(input bit sel8, input logic [7:0] d, input logic l);
    int unsigned n;
    n = 0;
    if (sel8) begin
      in8_if.tvalid = 1'b1; in8_if.tdata = d; in8_if.tlast = l;
    end else begin
      in_if.tvalid = 1'b1; in_if.tdata = d; in_if.tlast = l;
    end
    #1;
    while (((sel8 ? in8_if.tready : in_if.tready) !== 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: tready=0 for 20 cycles, required 1");
    end
    @(negedge clk);
    if (sel8) begin
      in8_if.tvalid = 1'b0; in8_if.tdata = '0; in8_if.tlast = 1'b0;
    end else begin
      in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tlast = 1'b0;
    end
  endtask

  // Accept four output beats of the 32-bit instance; returns at the negedge after the last transfer.
  task automatic collect(output logic [31:0] data, output logic [3:0] lasts);
    int unsigned n;
    data  = '0;
    lasts = '0;
    out_if.tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (out_if.tvalid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        compared++; mismatched++;
        $display("FAIL collect_timeout: tvalid=0 for 20 cycles at beat %0d, required 1", b);
      end
      data[b*8 +: 8] = out_if.tdata;
      lasts[b]       = out_if.tlast;
      @(negedge clk);
    end
    out_if.tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_if.tvalid = 1'b1; in_if.tdata = 8'h55; in_if.tlast = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (out_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL rst_tvalid: got %b, required 0", out_if.tvalid); end
    compared++;
    if (out_if.tlast !== 1'b0) begin mismatched++; $display("FAIL rst_tlast: got %b, required 0", out_if.tlast); end
    compared++;
    if (out_if.tdata !== 8'h00) begin mismatched++; $display("FAIL rst_tdata: got %h, required 00", out_if.tdata); end
    compared++;
    if (in_if.tready !== 1'b0) begin mismatched++; $display("FAIL rst_tready: got %b, required 0", in_if.tready); end
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("FAIL rst_overflow: got %b, required 0", ovf); end
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tlast = 1'b0;
    rst = 1'b0;
    #1;
    compared++;
    if (in_if.tready !== 1'b1) begin mismatched++; $display("FAIL rst_release_tready: got %b, required 1", in_if.tready); end
    @(negedge clk);
    compared++;
    if (out_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL rst_release_tvalid: got %b, required 0", out_if.tvalid); end
  endtask

  task automatic test_sum_basic();
    logic [31:0] data;
    logic [3:0]  lasts;
    send_beat(1'b0, 8'h02, 1'b0);
    send_beat(1'b0, 8'h03, 1'b0);
    send_beat(1'b0, 8'h05, 1'b1);
    compared++;
    if (ovf !== 1'b0) begin mismatched++; $display("FAIL basic_overflow: got %b, required 0", ovf); end
    collect(data, lasts);
    compared++;
    if (data !== 32'h0000000A) begin mismatched++; $display("FAIL basic_sum: got %h, required 0000000a", data); end
    compared++;
    if (lasts !== 4'b1000) begin mismatched++; $display("FAIL basic_tlast: got %b, required 1000", lasts); end
  endtask

  task automatic test_single_beat();
    logic [31:0] data;
    logic [3:0]  lasts;
    compared++;
    if (out_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL single_idle_tvalid: got %b, required 0", out_if.tvalid); end
    send_beat(1'b0, 8'hFF, 1'b1);
    compared++;
    if (out_if.tvalid !== 1'b1) begin mismatched++; $display("FAIL single_tvalid_latency: got %b, required 1", out_if.tvalid); end
    compared++;
    if (out_if.tdata !== 8'hFF) begin mismatched++; $display("FAIL single_first_beat: got %h, required ff", out_if.tdata); end
    collect(data, lasts);
    compared++;
    if (data !== 32'h000000FF) begin mismatched++; $display("FAIL single_sum: got %h, required 000000ff", data); end
    compared++;
    if (lasts !== 4'b1000) begin mismatched++; $display("FAIL single_tlast: got %b, required 1000", lasts); end
  endtask

  task automatic test_backpressure();
    send_beat(1'b0, 8'hFF, 1'b0);
    send_beat(1'b0, 8'h03, 1'b1);
    out_if.tready = 1'b1;
    compared++;
    if (out_if.tdata !== 8'h02) begin mismatched++; $display("FAIL bp_beat0: got %h, required 02", out_if.tdata); end
    @(negedge clk);
    out_if.tready = 1'b0;
    compared++;
    if (out_if.tdata !== 8'h01) begin mismatched++; $display("FAIL bp_beat1: got %h, required 01", out_if.tdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'h01 || out_if.tlast !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold: cycle %0d got v=%b d=%h l=%b, required v=1 d=01 l=0",
                 i, out_if.tvalid, out_if.tdata, out_if.tlast);
      end
    end
    out_if.tready = 1'b1;
    @(negedge clk);
    compared++;
    if (out_if.tdata !== 8'h00 || out_if.tlast !== 1'b0) begin
      mismatched++; $display("FAIL bp_beat2: got d=%h l=%b, required d=00 l=0", out_if.tdata, out_if.tlast);
    end
    @(negedge clk);
    compared++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'h00 || out_if.tlast !== 1'b1) begin
      mismatched++; $display("FAIL bp_beat3: got v=%b d=%h l=%b, required v=1 d=00 l=1",
                             out_if.tvalid, out_if.tdata, out_if.tlast);
    end
    @(negedge clk);
    out_if.tready = 1'b0;
    compared++;
    if (out_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL bp_done_tvalid: got %b, required 0", out_if.tvalid); end
  endtask

  task automatic test_overflow8();
    send_beat(1'b1, 8'hF0, 1'b0);
    compared++;
    if (ovf8 !== 1'b0) begin mismatched++; $display("FAIL ovf8_early: got %b, required 0", ovf8); end
    send_beat(1'b1, 8'h20, 1'b1);
    compared++;
    if (out8_if.tvalid !== 1'b1) begin mismatched++; $display("FAIL ovf8_tvalid: got %b, required 1", out8_if.tvalid); end
    compared++;
    if (out8_if.tdata !== EXP8) begin mismatched++; $display("FAIL ovf8_sum: got %h, required %h", out8_if.tdata, EXP8); end
    compared++;
    if (out8_if.tlast !== 1'b1) begin mismatched++; $display("FAIL ovf8_tlast: got %b, required 1", out8_if.tlast); end
    compared++;
    if (ovf8 !== 1'b1) begin mismatched++; $display("FAIL ovf8_flag: got %b, required 1", ovf8); end
    out8_if.tready = 1'b1;
    @(negedge clk);
    out8_if.tready = 1'b0;
    compared++;
    if (out8_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL ovf8_done_tvalid: got %b, required 0", out8_if.tvalid); end
    @(negedge clk);
    compared++;
    if (ovf8 !== 1'b0) begin mismatched++; $display("FAIL ovf8_cleared: got %b, required 0", ovf8); end
  endtask

  task automatic test_reset_mid_accumulate();
    logic [31:0] data;
    logic [3:0]  lasts;
    send_beat(1'b0, 8'h33, 1'b0);
    send_beat(1'b0, 8'h44, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_beat(1'b0, 8'h04, 1'b1);
    collect(data, lasts);
    compared++;
    if (data !== 32'h00000004) begin mismatched++; $display("FAIL rst_acc_sum: got %h, required 00000004", data); end
  endtask

  task automatic test_reset_mid_emit();
    logic [31:0] data;
    logic [3:0]  lasts;
    send_beat(1'b0, 8'h10, 1'b0);
    send_beat(1'b0, 8'h20, 1'b1);
    out_if.tready = 1'b1;
    repeat (2) @(negedge clk);
    out_if.tready = 1'b0;
    compared++;
    if (out_if.tvalid !== 1'b1 || out_if.tlast !== 1'b0) begin
      mismatched++; $display("FAIL emit_beat2: got v=%b l=%b, required v=1 l=0", out_if.tvalid, out_if.tlast);
    end
    #1 rst = 1'b1;
    #1;
    compared++;
    if (out_if.tvalid !== 1'b0) begin mismatched++; $display("FAIL emit_async_tvalid: got %b, required 0", out_if.tvalid); end
    compared++;
    if (in_if.tready !== 1'b0) begin mismatched++; $display("FAIL emit_async_tready: got %b, required 0", in_if.tready); end
    @(negedge clk);
    rst = 1'b0;
    send_beat(1'b0, 8'h01, 1'b0);
    send_beat(1'b0, 8'h01, 1'b1);
    collect(data, lasts);
    compared++;
    if (data !== 32'h00000002) begin mismatched++; $display("FAIL emit_rst_sum: got %h, required 00000002", data); end
    compared++;
    if (lasts !== 4'b1000) begin mismatched++; $display("FAIL emit_rst_tlast: got %b, required 1000", lasts); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data;
    logic [3:0]  lasts;
    send_beat(1'b0, 8'h04, 1'b1);
    collect(data, lasts);
    compared++;
    if (data !== 32'h00000004) begin mismatched++; $display("FAIL b2b_first: got %h, required 00000004", data); end
    compared++;
    if (in_if.tready !== 1'b0) begin mismatched++; $display("FAIL b2b_clear_tready: got %b, required 0", in_if.tready); end
    @(negedge clk);
    compared++;
    if (in_if.tready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_again: got %b, required 1", in_if.tready); end
    send_beat(1'b0, 8'h07, 1'b1);
    collect(data, lasts);
    compared++;
    if (data !== 32'h00000007) begin mismatched++; $display("FAIL b2b_second: got %h, required 00000007", data); end
    compared++;
    if (lasts !== 4'b1000) begin mismatched++; $display("FAIL b2b_tlast: got %b, required 1000", lasts); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    in_if.tvalid  = 1'b0; in_if.tdata  = '0; in_if.tlast  = 1'b0;
    in8_if.tvalid = 1'b0; in8_if.tdata = '0; in8_if.tlast = 1'b0;
    out_if.tready  = 1'b0;
    out8_if.tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sum_basic();
    test_single_beat();
    test_backpressure();
    test_overflow8();
    test_reset_mid_accumulate();
    test_reset_mid_emit();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
